// File: rtl/counter_ctrl.sv
// counter_ctrl
// Control stage in front of an up/down counter. Converts a level run request
// plus a programmable prescale divisor into single-cycle count-enable strobes,
// and turns each value accepted over a valid/ready handshake into exactly one
// registered load pulse. A load suppresses any strobe in its cycle and
// restarts the prescale period.
//
// Ports:
//   clk        in   rising-edge clock
//   asyn_rst   in   asynchronous active-high reset
//   run        in   level, 1 requests counting
//   div        in   prescale divisor, strobe period is div+1 cycles
//   cmd_valid  in   load value offered on cmd_data
//   cmd_data   in   load value
//   cmd_ready  out  registered, block can accept a load value
//   enb        out  registered count-enable strobe
//   load       out  registered single-cycle load pulse
//   data_in    out  registered load value, valid while load=1, held otherwise
//   running    out  registered, 1 in RUN or in LOAD with run high
module counter_ctrl #(
  parameter int WIDTH     = 4,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 asyn_rst,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 cmd_valid,
  input  logic [WIDTH-1:0]     cmd_data,
  output logic                 cmd_ready,
  output logic                 enb,
  output logic                 load,
  output logic [WIDTH-1:0]     data_in,
  output logic                 running
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } state_t;

  localparam logic [DIV_WIDTH-1:0] PC_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_reg, state_next;
  logic [DIV_WIDTH-1:0]   pc_reg, pc_next;
  logic [DIV_WIDTH-1:0]   div_lat_reg, div_lat_next;
  logic                   enb_next;
  logic                   load_next;
  logic [WIDTH-1:0]       data_next;
  logic                   cmd_ready_next;
  logic                   running_next;
  logic                   xfer;

  // cmd_ready is registered, so a transfer depends only on registered state
  // and cmd_valid.
  assign xfer = cmd_valid & cmd_ready;

  always_ff @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      state_reg   <= IDLE;
      pc_reg      <= '0;
      div_lat_reg <= '0;
      enb         <= 1'b0;
      load        <= 1'b0;
      data_in     <= '0;
      cmd_ready   <= 1'b0;
      running     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      div_lat_reg <= div_lat_next;
      enb         <= enb_next;
      load        <= load_next;
      data_in     <= data_next;
      cmd_ready   <= cmd_ready_next;
      running     <= running_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    div_lat_next = div_lat_reg;
    enb_next     = 1'b0;
    load_next    = xfer;
    data_next    = xfer ? cmd_data : data_in;

    case (state_reg)
      IDLE: begin
        pc_next = '0;
        if (xfer) begin
          state_next = LOAD;
        end else if (run) begin
          state_next   = RUN;
          div_lat_next = div;
        end
      end

      RUN: begin
        // A transfer wins over a strobe due on the same edge; the strobe is
        // dropped and the period restarts after the load.
        if (xfer) begin
          state_next = LOAD;
          pc_next    = '0;
        end else if (!run) begin
          state_next = IDLE;
          pc_next    = '0;
        end else if (pc_reg == div_lat_reg) begin
          // Wrap: strobe next cycle and pick up any new divisor so a change
          // mid-period only affects the following period.
          pc_next      = '0;
          enb_next     = 1'b1;
          div_lat_next = div;
        end else begin
          pc_next = pc_reg + PC_ONE;
        end
      end

      LOAD: begin
        pc_next = '0;
        if (run) begin
          state_next   = RUN;
          div_lat_next = div;
        end else begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        pc_next    = '0;
      end
    endcase

    // Never ready during LOAD, which spaces accepted commands >= 2 cycles.
    cmd_ready_next = (state_next != LOAD);
    running_next   = (state_next == RUN) || ((state_next == LOAD) && run);
  end

endmodule

// File: tb/tb_counter_ctrl.sv
module tb_counter_ctrl;

  logic       clk;
  logic       asyn_rst;
  logic       run;
  logic [7:0] div;
  logic       cmd_valid;
  logic [3:0] cmd_data;
  logic       cmd_ready;
  logic       enb;
  logic       load;
  logic [3:0] data_in;
  logic       running;

  int checks = 0;
  int errors = 0;

  counter_ctrl #(.WIDTH(4), .DIV_WIDTH(8)) dut (
    .clk       (clk),
    .asyn_rst  (asyn_rst),
    .run       (run),
    .div       (div),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .enb       (enb),
    .load      (load),
    .data_in   (data_in),
    .running   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // load and enb must never coincide.
  always @(negedge clk) begin
    if (!asyn_rst) check("excl", 32'(load & enb), 32'd0);
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_enb"},   32'(enb),       32'd0);
    check({tag, "_load"},  32'(load),      32'd0);
    check({tag, "_data"},  32'(data_in),   32'd0);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, "_run"},   32'(running),   32'd0);
  endtask

  initial begin
    asyn_rst  = 1'b0;
    run       = 1'b0;
    div       = 8'd3;
    cmd_valid = 1'b0;
    cmd_data  = 4'h0;

    // ---- reset and strobe rate, div=3 ----
    #2 asyn_rst = 1'b1;
    #1 check_reset_outputs("rst_async");
    step();
    step();
    check_reset_outputs("rst_held");
    asyn_rst = 1'b0;
    step();
    check("rel_ready", 32'(cmd_ready), 32'd1);
    check("rel_enb", 32'(enb), 32'd0);
    run = 1'b1;
    div = 8'd3;
    step();                                   // entry edge
    check("entry_enb", 32'(enb), 32'd0);
    check("entry_running", 32'(running), 32'd1);
    for (int i = 1; i <= 12; i++) begin
      step();
      check($sformatf("rate3_%0d", i), 32'(enb), (i % 4 == 0) ? 32'd1 : 32'd0);
    end
    $display("phase reset/rate done");

    // ---- load during run, div=2 ----
    run = 1'b0;
    step();
    check("stop_running", 32'(running), 32'd0);
    div = 8'd2;
    run = 1'b1;
    step();                                   // S: enter RUN
    step();
    step();
    step();                                   // S+3
    check("d2_first_enb", 32'(enb), 32'd1);
    cmd_valid = 1'b1;
    cmd_data  = 4'hA;
    step();                                   // S+4: transfer
    cmd_valid = 1'b0;
    check("ld_load", 32'(load), 32'd1);
    check("ld_data", 32'(data_in), 32'hA);
    check("ld_enb", 32'(enb), 32'd0);
    check("ld_ready", 32'(cmd_ready), 32'd0);
    check("ld_running", 32'(running), 32'd1);
    step();                                   // S+5: back to RUN
    check("ld_end_load", 32'(load), 32'd0);
    check("ld_hold_data", 32'(data_in), 32'hA);
    check("ld_end_ready", 32'(cmd_ready), 32'd1);
    step();
    check("post_ld_1", 32'(enb), 32'd0);
    step();
    check("post_ld_2", 32'(enb), 32'd0);
    step();                                   // S+8
    check("post_ld_3", 32'(enb), 32'd1);
    $display("phase load-during-run done");

    // ---- collision: transfer on the edge a strobe is due ----
    step();
    check("col_pre_1", 32'(enb), 32'd0);
    step();
    check("col_pre_2", 32'(enb), 32'd0);
    cmd_valid = 1'b1;
    cmd_data  = 4'h5;
    step();                                   // S+11: strobe would fire
    cmd_valid = 1'b0;
    check("col_load", 32'(load), 32'd1);
    check("col_enb", 32'(enb), 32'd0);
    check("col_data", 32'(data_in), 32'h5);
    step();
    check("col_after_enb", 32'(enb), 32'd0);
    step();
    step();
    step();                                   // S+15
    check("col_next_enb", 32'(enb), 32'd1);
    $display("phase collision done");

    // ---- back-to-back commands 1,2,3 ----
    cmd_valid = 1'b1;
    cmd_data  = 4'h1;
    for (int i = 1; i <= 6; i++) begin
      step();
      check($sformatf("b2b_load_%0d", i), 32'(load), (i % 2 == 1) ? 32'd1 : 32'd0);
      check($sformatf("b2b_data_%0d", i), 32'(data_in), 32'((i + 1) / 2));
      if (i == 1) cmd_data = 4'h2;
      if (i == 3) cmd_data = 4'h3;
      if (i == 5) cmd_valid = 1'b0;
    end
    $display("phase back-to-back done");

    // ---- divisor change 5 -> 1 mid-period ----
    run = 1'b0;
    step();
    div = 8'd5;
    run = 1'b1;
    step();                                   // R: enter RUN with div 5
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("divchg_%0d", i), 32'(enb),
            (i == 6 || i == 8 || i == 10) ? 32'd1 : 32'd0);
      if (i == 2) div = 8'd1;
    end

    // ---- div = 0 ----
    run = 1'b0;
    step();
    div = 8'd0;
    run = 1'b1;
    step();
    check("div0_entry", 32'(enb), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("div0_%0d", i), 32'(enb), 32'd1);
    end
    $display("phase divisor done");

    // ---- stop one cycle before a strobe ----
    run = 1'b0;
    step();
    div = 8'd3;
    run = 1'b1;
    step();                                   // Y
    step();
    step();
    step();                                   // Y+3
    run = 1'b0;
    step();                                   // Y+4: strobe would fire
    check("stop_enb", 32'(enb), 32'd0);
    check("stop_running", 32'(running), 32'd0);
    step();
    check("stop_enb_after", 32'(enb), 32'd0);

    // ---- reset during LOAD ----
    cmd_valid = 1'b1;
    cmd_data  = 4'h7;
    step();
    check("abort_load_pre", 32'(load), 32'd1);
    check("abort_data_pre", 32'(data_in), 32'h7);
    #3 asyn_rst = 1'b1;
    #1 check_reset_outputs("abort");
    step();                                   // transfer offered during reset
    check_reset_outputs("abort_held");
    asyn_rst  = 1'b0;
    cmd_valid = 1'b0;
    step();
    check("abort_rel_ready", 32'(cmd_ready), 32'd1);
    check("abort_rel_load", 32'(load), 32'd0);
    $display("phase stop/abort done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
